// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: collects button press pulses and offers them one at a time over a valid/ready handshake
module btn_event_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] press,
  output logic       ev_valid,
  output logic [1:0] ev_id,
  input  logic       ev_ready,
  output logic [3:0] pending,
  output logic [3:0] overrun,
  input  logic       ovr_clr
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;
  logic [0:0] r_state;
  logic [1:0] r_id;
  logic [1:0] r_ptr;
  logic [3:0] r_pend;
  logic [3:0] r_ovr;
  logic       w_grant;
  logic [1:0] w_base;
  logic [1:0] w_win;
  logic [3:0] w_clr;
  logic [3:0] w_ovr_set;
  // Search the registered pending bits upward from the base index, wrapping 3 -> 0
  always_comb begin
    w_base = (ROUND_ROBIN != 0) ? r_ptr : 2'd0;
    w_win  = w_base;
    for (int k = 3; k >= 0; k--)
      if (r_pend[w_base + 2'(k)]) w_win = w_base + 2'(k);
  end
  assign w_grant   = (r_state == IDLE || ev_ready) && |r_pend;
  assign w_clr     = w_grant ? (4'b0001 << w_win) : 4'b0000;
  assign w_ovr_set = press & r_pend & ~w_clr;
  // Handshake state, offered id and round-robin pointer; pointer moves only on a grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_id    <= 2'd0;
      r_ptr   <= 2'd0;
    end else if (w_grant) begin
      r_state <= OFFER;
      r_id    <= w_win;
      r_ptr   <= w_win + 2'd1;
    end else if (ev_ready) begin
      r_state <= IDLE;
    end
  end
  // Pending events and sticky overruns; a press on the grant edge becomes a fresh event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 4'b0;
      r_ovr  <= 4'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | press;
      r_ovr  <= (ovr_clr ? 4'b0 : r_ovr) | w_ovr_set;
    end
  end
  assign ev_valid = (r_state == OFFER);
  assign ev_id    = r_id;
  assign pending  = r_pend;
  assign overrun  = r_ovr;
endmodule
